bcd_scan_mux: RTL
=================

# bcd_scan_mux

Four-digit multiplexed display scanner sitting directly upstream of the BCD-to-7-segment decoder. Captures a 16-bit packed-BCD value and time-multiplexes one digit at a time onto the decoder's 4-bit BCD input (a = MSB … d = LSB), driving matching active-low digit enables. Provides anti-ghosting blank slots, optional leading-zero blanking and invalid-digit detection.

## Interface

Parameters:
- PRESCALE, 50000: clock cycles per digit slot; legal range ≥ 2; counter width = clog2(PRESCALE).
- BLANK_LZ, 1: 1 = suppress leading zeros; 0 = show all four digits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; samples value.
- value  in  16  packed BCD; [15:12] = digit 3 (most significant), [3:0] = digit 0.
- a, b, c, d  out  1 each  current digit's BCD to the decoder; a = bit 3, d = bit 0.
- an  out  4  active-low digit enables; an[i] low lights digit i.
- err  out  1  high after a load containing any nibble > 9.

## Operation

- State registers: disp (16 b), idx (2 b), cnt (prescale counter), err.
- Reset: disp = 0x0000, idx = 0, cnt = 0, err = 0; hence an = 4'b1111 and a..d = 0000 while rst is high.
- Load, all nibbles ≤ 9: disp ← value, err ← 0 on the next edge.
- Load, any nibble > 9: disp unchanged, err ← 1; err stays high until a valid load or reset.
- Load mid-slot: scan position and cnt unaffected; the new digit appears on a..d in the cycle after the load edge.
- Prescaler: cnt counts 0 … PRESCALE-1, then wraps to 0. On the edge where cnt wraps, idx ← idx+1 mod 4.
- Scan order: 0 → 1 → 2 → 3 → 0.
- a..d = disp nibble selected by idx. Outputs are combinational from registers only; no input-to-output paths.
- an:
  - cnt == 0 → 4'b1111 (anti-ghost blank cycle at the start of every slot).
  - otherwise, an[idx] = 0 and the other bits = 1, unless slot idx is blanked.
- Leading-zero blanking, BLANK_LZ = 1: slot i (i ≥ 1) is blanked when disp digit i and all more-significant digits are 0. Slot 0 is never blanked, so 0x0000 shows a single "0".
- Blanking does not alter a..d; only an is suppressed.
- err has no effect on scanning.

## Timing

- Slot length: PRESCALE cycles; 1 blank cycle plus PRESCALE-1 lit cycles.
- Full refresh period: 4·PRESCALE cycles.
- After rst deasserts:
  - cycle 0: cnt = 0, an = 1111.
  - cycles 1 … PRESCALE-1: digit 0 lit.
  - cycle PRESCALE: idx = 1, an = 1111.
- Load-to-display latency: 1 edge.
- load asserted on the same edge that idx advances: both take effect together; the new slot shows the new disp digit.
- Reset asserted mid-slot: all state clears immediately (asynchronous); scanning restarts from idx 0, cnt 0.
- PRESCALE = 2: alternating blank/lit cycles, one lit cycle per digit.

## Test plan

- Reset: hold rst with clk running → an = 1111, a..d = 0000, err = 0. Release → an = 1111 for 1 cycle, then an = 1110 with a..d = 0000.
- Scan order (PRESCALE = 4, BLANK_LZ = 1): load 0x1234 → repeating 16-cycle pattern:
  - idx 0: 1111, then 1110 ×3 with abcd = 0100.
  - idx 1: 1111, then 1101 ×3 with 0011.
  - idx 2: 1111, then 1011 ×3 with 0010.
  - idx 3: 1111, then 0111 ×3 with 0001.
- Leading-zero blanking: load 0x0050 → an stays 1111 during slots 3 and 2; slot 1 shows abcd 0101 with an 1101; slot 0 shows 0000 with an 1110. Repeat with BLANK_LZ = 0 → all four slots lit.
- Zero value: load 0x0000 (BLANK_LZ = 1) → only slot 0 lit (an = 1110, abcd = 0000); an = 1111 elsewhere.
- Invalid load: load 0x1234, then 0x12A4 → err = 1 next cycle, display still 1234. Then load 0x0009 → err = 0 and 0009 is shown as a single lit digit.
- Reset mid-scan: assert rst during slot 2, between edges → an = 1111 and abcd = 0000 immediately, disp = 0. After release, scanning restarts at slot 0.

Source files
------------

// File: rtl/bcd_scan_mux_if.sv
// Bus between a BCD display source and the scanner: load/value in,
// multiplexed digit code, active-low digit enables and error flag out.
interface bcd_scan_mux_if;
    logic        load;
    logic [15:0] value;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic [3:0]  an;
    logic        err;

    modport master (
        output load, value,
        input  a, b, c, d, an, err
    );

    modport slave (
        input  load, value,
        output a, b, c, d, an, err
    );
endinterface

// File: rtl/bcd_scan_mux.sv
// Four-digit multiplexed display scanner feeding a BCD-to-7-segment decoder,
// with a blank cycle per slot, leading-zero blanking and invalid-digit flag.
module bcd_scan_mux #(
    parameter int PRESCALE = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    bcd_scan_mux_if.slave  bus
);

    localparam int             CW       = $clog2(PRESCALE);
    localparam logic [CW-1:0]  CNT_LAST = CW'(PRESCALE - 1);

    logic [15:0]   r_disp;
    logic [1:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    logic          w_valid;
    logic [3:0]    w_blank;
    logic [3:0]    w_digit;
    logic [3:0]    w_an;

    always_comb begin
        w_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.value[4*i +: 4] > 4'd9) w_valid = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; a load on the wrap edge lands with the new idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (bus.load) begin
                if (w_valid) begin
                    r_disp <= bus.value;
                    r_err  <= 1'b0;
                end else begin
                    r_err  <= 1'b1;
                end
            end
        end
    end

    // Slot i is blank when digit i and everything above it is zero; slot 0 never.
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        w_blank = 4'b0000;
        if (BLANK_LZ) begin
            w_blank[3] = (r_disp[15:12] == 4'd0);
            w_blank[2] = (r_disp[15:8]  == 8'd0);
            w_blank[1] = (r_disp[15:4]  == 12'd0);
        end
    end

    always_comb begin
        w_digit = r_disp[{r_idx, 2'b00} +: 4];
        w_an    = 4'b1111;
        if (r_cnt != '0 && !w_blank[r_idx]) w_an = ~(4'b0001 << r_idx);
    end

    assign {bus.a, bus.b, bus.c, bus.d} = w_digit;
    assign bus.an                       = w_an;
    assign bus.err                      = r_err;

endmodule
